// File: rtl/can_tx_mailbox.sv
`default_nettype none
// ============================================================================
// Module      : can_tx_mailbox
// Description : CAN transmit mailboxes with lowest-ID arbitration, abort and
//               retransmission handling in front of a CAN tx engine.
//               Optional retry limit: define CAN_TX_RETRY_LIMIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module can_tx_mailbox #(
    parameter int NUM_MB    = 4,
    parameter int ID_W      = 11,
    parameter int MAX_RETRY = 7
) (
    input  logic                      clk,
    input  logic                      RESET,
    input  logic                      wr_en,
    input  logic [$clog2(NUM_MB)-1:0] wr_idx,
    input  logic [ID_W-1:0]           wr_id,
    input  logic [3:0]                wr_dlc,
    input  logic [63:0]               wr_data,
    input  logic                      abort_en,
    input  logic [$clog2(NUM_MB)-1:0] abort_idx,
    output logic [NUM_MB-1:0]         pending,
    output logic                      wr_rej,
    output logic [NUM_MB-1:0]         done,
    output logic [NUM_MB-1:0]         aborted,
    output logic [NUM_MB-1:0]         failed,
    output logic                      tx_req,
    output logic [ID_W-1:0]           tx_id,
    output logic [3:0]                tx_dlc,
    output logic [63:0]               tx_data,
    input  logic                      tx_ack,
    input  logic                      tx_done,
    input  logic                      tx_arb_lost,
    input  logic                      tx_err
);
    localparam int             IDX_W    = $clog2(NUM_MB);
    localparam logic [IDX_W:0] C_NUM_MB = (IDX_W + 1)'(NUM_MB);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        REQ    = 2'd2,
        WAIT   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_MB-1:0]   pending_q, pending_d;
    logic [IDX_W-1:0]    infl_q, infl_d;
    logic                abort_def_q, abort_def_d;
    logic                wr_rej_q, wr_rej_d;
    logic [NUM_MB-1:0]   done_q, done_d;
    logic [NUM_MB-1:0]   aborted_q, aborted_d;

    logic [ID_W-1:0]     mb_id_q   [NUM_MB];
    logic [3:0]          mb_dlc_q  [NUM_MB];
    logic [63:0]         mb_data_q [NUM_MB];

`ifdef CAN_TX_RETRY_LIMIT_EN
    localparam int RTY_W = $clog2(MAX_RETRY + 1);
    logic [RTY_W-1:0]    retry_q [NUM_MB];
    logic [RTY_W-1:0]    retry_d [NUM_MB];
    logic [NUM_MB-1:0]   failed_q, failed_d;
`endif

    logic                wr_hit, ab_hit, in_flight;
    logic                wr_to_infl, ab_to_infl, wr_clash, wr_ok;
    logic [NUM_MB-1:0]   ab_mask, cand;
    logic                sel_found;
    logic [IDX_W-1:0]    sel_idx;
    logic [ID_W-1:0]     sel_id;

    assign wr_hit     = wr_en    && ({1'b0, wr_idx}    < C_NUM_MB);
    assign ab_hit     = abort_en && ({1'b0, abort_idx} < C_NUM_MB);
    assign in_flight  = (state_q == REQ) || (state_q == WAIT);
    assign wr_to_infl = in_flight && (wr_idx == infl_q);
    assign ab_to_infl = in_flight && (abort_idx == infl_q);
    // Abort beats a write to the same mailbox in the same cycle.
    assign wr_clash   = ab_hit && (abort_idx == wr_idx);
    assign wr_ok      = wr_hit && !wr_to_infl && !wr_clash;
    assign ab_mask    = ab_hit ? (NUM_MB'(1) << abort_idx) : '0;
    assign cand       = pending_q & ~ab_mask;

    // Lowest identifier wins; strict compare keeps ties on the lowest index.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_id    = '0;
        for (int i = 0; i < NUM_MB; i++) begin
            if (cand[i] && (!sel_found || (mb_id_q[i] < sel_id))) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_id    = mb_id_q[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        infl_d      = infl_q;
        abort_def_d = abort_def_q;
        done_d      = '0;
        aborted_d   = '0;
        wr_rej_d    = wr_hit && (wr_to_infl || wr_clash);
`ifdef CAN_TX_RETRY_LIMIT_EN
        failed_d    = '0;
        retry_d     = retry_q;
`endif

        if (wr_ok) begin
            pending_d[wr_idx] = 1'b1;
`ifdef CAN_TX_RETRY_LIMIT_EN
            retry_d[wr_idx]   = '0;
`endif
        end

        if (ab_hit) begin
            if (ab_to_infl) begin
                abort_def_d = 1'b1;
            end else if (pending_q[abort_idx]) begin
                pending_d[abort_idx] = 1'b0;
                aborted_d[abort_idx] = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (|pending_q) state_d = SELECT;
            end
            SELECT: begin
                if (sel_found) begin
                    infl_d  = sel_idx;
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (tx_ack) state_d = WAIT;
            end
            WAIT: begin
                if (tx_done) begin
                    pending_d[infl_q] = 1'b0;
                    done_d[infl_q]    = 1'b1;
                    state_d           = IDLE;
                end else if (tx_arb_lost || tx_err) begin
                    if (abort_def_d) begin
                        pending_d[infl_q] = 1'b0;
                        aborted_d[infl_q] = 1'b1;
                        state_d           = IDLE;
                    end else if (tx_arb_lost) begin
                        state_d = SELECT;
                    end else begin
`ifdef CAN_TX_RETRY_LIMIT_EN
                        if (retry_q[infl_q] == RTY_W'(MAX_RETRY - 1)) begin
                            pending_d[infl_q] = 1'b0;
                            failed_d[infl_q]  = 1'b1;
                            retry_d[infl_q]   = '0;
                            state_d           = IDLE;
                        end else begin
                            retry_d[infl_q] = retry_q[infl_q] + 1'b1;
                            state_d         = SELECT;
                        end
`else
                        state_d = SELECT;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if ((state_d != REQ) && (state_d != WAIT)) abort_def_d = 1'b0;
    end

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            infl_q      <= '0;
            abort_def_q <= 1'b0;
            wr_rej_q    <= 1'b0;
            done_q      <= '0;
            aborted_q   <= '0;
`ifdef CAN_TX_RETRY_LIMIT_EN
            failed_q    <= '0;
            for (int i = 0; i < NUM_MB; i++) retry_q[i] <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            infl_q      <= infl_d;
            abort_def_q <= abort_def_d;
            wr_rej_q    <= wr_rej_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
`ifdef CAN_TX_RETRY_LIMIT_EN
            failed_q    <= failed_d;
            retry_q     <= retry_d;
`endif
        end
    end

    // Frame storage carries no reset; contents are only observed once pending.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mb_id_q[wr_idx]   <= wr_id;
            mb_dlc_q[wr_idx]  <= (wr_dlc > 4'd8) ? 4'd8 : wr_dlc;
            mb_data_q[wr_idx] <= wr_data;
        end
    end

    assign pending = pending_q;
    assign wr_rej  = wr_rej_q;
    assign done    = done_q;
    assign aborted = aborted_q;
`ifdef CAN_TX_RETRY_LIMIT_EN
    assign failed  = failed_q;
`else
    assign failed  = '0;
`endif
    assign tx_req  = (state_q == REQ);
    assign tx_id   = tx_req ? mb_id_q[infl_q]   : '0;
    assign tx_dlc  = tx_req ? mb_dlc_q[infl_q]  : '0;
    assign tx_data = tx_req ? mb_data_q[infl_q] : '0;

endmodule
`default_nettype wire

// File: doc/can_tx_mailbox.md
CAN_TX_MAILBOX -- requirements
Module: can_tx_mailbox

Interface
REQ-001 The block SHALL take the following parameters, one per line: name, default, meaning.
- NUM_MB, 4, number of transmit mailboxes (legal 2..8).
- ID_W, 11, identifier width (11 standard, 29 extended).
- MAX_RETRY, 7, error retransmissions allowed before a mailbox fails (used only under REQ-022).
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk, in, 1, system clock; the only clock.
- RESET, in, 1, asynchronous active-low reset.
- wr_en, in, 1, load a mailbox this cycle.
- wr_idx, in, clog2(NUM_MB), mailbox to load.
- wr_id, in, ID_W, frame identifier.
- wr_dlc, in, 4, data length code.
- wr_data, in, 64, payload, byte 0 in bits [63:56].
- abort_en, in, 1, abort request this cycle.
- abort_idx, in, clog2(NUM_MB), mailbox to abort.
- pending, out, NUM_MB, mailbox holds a frame awaiting transmission.
- wr_rej, out, 1, one-cycle pulse: the write was refused.
- done, out, NUM_MB, one-cycle pulse per mailbox: frame sent.
- aborted, out, NUM_MB, one-cycle pulse per mailbox: frame aborted.
- failed, out, NUM_MB, one-cycle pulse per mailbox: retry limit reached.
- tx_req, out, 1, frame offered to the tx engine.
- tx_id, out, ID_W, identifier of the offered frame.
- tx_dlc, out, 4, DLC of the offered frame.
- tx_data, out, 64, payload of the offered frame.
- tx_ack, in, 1, engine accepted the offered frame.
- tx_done, in, 1, engine pulse: frame sent successfully.
- tx_arb_lost, in, 1, engine pulse: arbitration lost.
- tx_err, in, 1, engine pulse: bus or ACK error.

Function
REQ-003 The FSM SHALL have the states IDLE, SELECT, REQ and WAIT.
REQ-004 In IDLE, if any pending bit is set, the FSM SHALL move to SELECT on the next cycle.
REQ-005 In SELECT, the block SHALL register the pending mailbox with the numerically lowest ID (ties go to the lowest index) as in-flight and move to REQ; this takes one cycle.
REQ-006 In REQ, tx_req SHALL be 1 and tx_id, tx_dlc and tx_data SHALL hold stable until the cycle tx_ack=1, after which the FSM moves to WAIT and tx_req drops.
REQ-007 In WAIT, tx_done SHALL clear the in-flight pending bit, pulse done[idx] on the next cycle and return the FSM to IDLE.
REQ-008 In WAIT, tx_arb_lost SHALL return the FSM to SELECT with the pending bit kept, so priority is re-evaluated.
REQ-009 In WAIT, tx_err SHALL increment the in-flight retry counter and return the FSM to SELECT.
REQ-010 Engine pulses received outside WAIT SHALL be ignored.
REQ-011 A wr_dlc value above 8 SHALL be stored as 8; payload bytes beyond the DLC SHALL be forwarded unchanged.
REQ-012 A write to a mailbox that is not in flight SHALL load or overwrite the mailbox, set its pending bit and zero its retry counter in the same edge.
REQ-013 A write to the in-flight mailbox (REQ or WAIT) SHALL be ignored and SHALL pulse wr_rej.
REQ-014 An abort of a non-in-flight pending mailbox SHALL clear its pending bit and pulse aborted[idx]; an abort of an empty mailbox SHALL have no effect.
REQ-015 An abort of the in-flight mailbox SHALL be deferred:
- tx_done: treat as done.
- tx_arb_lost or tx_err: clear the pending bit, pulse aborted[idx], go to IDLE.
REQ-016 When wr_en and abort_en target the same index in the same cycle, the abort SHALL win and wr_rej SHALL pulse.
REQ-017 In any one cycle, at most one of done, aborted and failed SHALL be set per mailbox.

Reset
REQ-018 While RESET=0, the FSM SHALL be in IDLE.
REQ-019 While RESET=0, all outputs (pending, wr_rej, done, aborted, failed, tx_req, tx_id, tx_dlc, tx_data) SHALL be 0 and all retry counters SHALL be 0.
REQ-020 When RESET is asserted mid-frame, the in-flight frame SHALL be discarded without any done, aborted or failed pulse.
REQ-021 Mailbox ID and payload storage need not be reset.

Configuration
REQ-022 When the macro CAN_TX_RETRY_LIMIT_EN is defined, the MAX_RETRY-th tx_err on a mailbox SHALL clear its pending bit, pulse failed[idx] and return the FSM to IDLE.
REQ-023 When CAN_TX_RETRY_LIMIT_EN is not defined, retransmission on error SHALL be unlimited, failed SHALL be tied to 0, and no retry counters SHALL be built.

Verification
REQ-024 The bench SHALL cover at least the following directed scenarios:
- Write mb0 id=0x25 and mb1 id=0x10 in the same idle window -> the first tx_req carries 0x10; after tx_done, done[1] pulses, then the next offer carries 0x25.
- Write mb2 id=0x100, then tx_ack, then tx_arb_lost; during WAIT write mb3 id=0x050 -> the next offer is 0x050.
- In WAIT, write to the in-flight index -> wr_rej pulses once and the mailbox contents are unchanged.
- Abort the in-flight mailbox, then tx_err -> aborted pulses and pending=0; repeat with tx_done instead -> done pulses.
- With CAN_TX_RETRY_LIMIT_EN and MAX_RETRY=3: three tx_err -> failed pulses on the third; without the macro: ten tx_err -> still pending.
- Drive RESET=0 during REQ -> tx_req=0 and pending=0 immediately, with no status pulses.
